// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: pairs camera bytes into pixels, converts them to 4-bit gray
// and writes whole, VSYNC-aligned frames into a raster-ordered frame buffer.
module ov7670_capture #(
  parameter int hRez = 640,
  parameter int vRez = 480
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_din,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [3:0]  wr_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int COL_W = $clog2(hRez) + 1;
  localparam int ROW_W = $clog2(vRez) + 1;

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  state_t           state, state_next;
  logic             vs_q, hr_q, vs_prev, hr_prev;
  logic [7:0]       d_q, byte0;
  logic             phase;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [18:0]      line_base;
  logic             vs_rise, vs_fall, hr_fall;
  logic             start, frame_end;
  logic             pix_ok;
  logic [6:0]       sum;

  // NOTE: every clocked process uses <= so all registers update from pre-edge values.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      d_q     <= '0;
      vs_prev <= 1'b0;
      hr_prev <= 1'b0;
    end else begin
      vs_q    <= cam_vsync;
      hr_q    <= cam_href;
      d_q     <= cam_din;
      vs_prev <= vs_q;
      hr_prev <= hr_q;
    end
  end

  assign vs_rise = vs_q & ~vs_prev;
  assign vs_fall = ~vs_q & vs_prev;
  assign hr_fall = ~hr_q & hr_prev;

  always_ff @(posedge pclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture_en) state_next = ARM;
      ARM: begin
        if (vs_fall)          state_next = CAPTURE;
        else if (!capture_en) state_next = IDLE;
      end
      CAPTURE: if (vs_rise) state_next = capture_en ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == CAPTURE);
    start     = (state == ARM) && vs_fall;
    frame_end = (state == CAPTURE) && vs_rise;
  end

  // R5 + G6 + B5 of the pixel completed by the byte now in d_q.
  assign sum    = {2'b00, byte0[7:3]} + {1'b0, byte0[2:0], d_q[7:5]} + {2'b00, d_q[4:0]};
  assign pix_ok = (col < COL_W'(hRez)) && (row < ROW_W'(vRez));

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      byte0      <= '0;
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= frame_end;
      if (start) begin
        phase     <= 1'b0;
        col       <= '0;
        row       <= '0;
        line_base <= '0;
      end else if (busy) begin
        if (hr_q) begin
          phase <= ~phase;
          if (!phase) begin
            byte0 <= d_q;
          end else begin
            if (pix_ok) begin
              wr_en   <= 1'b1;
              wr_addr <= line_base + 19'(col);
              wr_data <= sum[6:3];
            end
            // Counters saturate so over-long lines or frames cannot wrap into the window.
            if (col != '1) col <= col + 1'b1;
          end
        end else begin
          phase <= 1'b0;
          if (hr_fall && col != '0) begin
            col       <= '0;
            line_base <= line_base + 19'(hRez);
            if (row != '1) row <= row + 1'b1;
          end
        end
      end else begin
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized directed bench for ov7670_capture: a frame-level reference model predicts
// every write (address, gray value, cycle) and every frame_done pulse.
module tb_ov7670_capture;

  localparam int HREZ = 640;
  localparam int VREZ = 4;

  logic        pclk = 1'b0;
  logic        rst_n, capture_en, cam_vsync, cam_href;
  logic [7:0]  cam_din;
  logic        wr_en, frame_done, busy;
  logic [18:0] wr_addr;
  logic [3:0]  wr_data;

  ov7670_capture #(.hRez(HREZ), .vRez(VREZ)) dut (
    .pclk(pclk), .rst_n(rst_n), .capture_en(capture_en),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_din(cam_din),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int addr; int data; int at;} wr_t;
  wr_t exp_wr[$];
  int  exp_fd[$];
  bit  capturing = 1'b0;
  bit  armed     = 1'b0;
  int  row_m     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic [7:0] b0, input logic [7:0] b1);
    int r = b0[7:3];
    int g = {b0[2:0], b1[7:5]};
    int b = b1[4:0];
    return (r + g + b) / 8;
  endfunction

  // Output monitor, sampled on the falling edge.
  logic prev_wr = 1'b0;
  wr_t  e;
  int   fd_at;
  always @(negedge pclk) begin
    if (wr_en) begin
      check("wr_gap", 32'(prev_wr), 32'd0);
      if (exp_wr.size() == 0) begin
        check("wr_unexpected_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), e.addr);
        check("wr_data", 32'(wr_data), e.data);
        check("wr_cycle", cyc, e.at);
      end
    end
    prev_wr = wr_en;
    if (frame_done) begin
      if (exp_fd.size() == 0) begin
        check("fd_unexpected_cycle", cyc, 32'hFFFF_FFFF);
      end else begin
        fd_at = exp_fd.pop_front();
        check("fd_cycle", cyc, fd_at);
      end
    end
  end

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge pclk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_din   = d;
  endtask

  task automatic send_line(input logic [7:0] bq[$]);
    for (int i = 0; i < bq.size(); i++) begin
      step(1'b0, 1'b1, bq[i]);
      if (i % 2 == 1 && capturing && (i / 2) < HREZ && row_m < VREZ)
        exp_wr.push_back('{row_m * HREZ + i / 2, gray(bq[i-1], bq[i]), cyc + 2});
    end
    if (capturing && bq.size() >= 2) row_m++;
    repeat (4) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic rand_line(input int n);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    send_line(q);
  endtask

  task automatic vsync_frame();
    step(1'b1, 1'b0, 8'h00);
    if (capturing) exp_fd.push_back(cyc + 2);
    capturing = 1'b0;
    armed     = capture_en;
    repeat (2) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    if (armed) begin
      capturing = 1'b1;
      armed     = 1'b0;
    end
    row_m = 0;
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic set_en(input logic v);
    @(negedge pclk);
    capture_en = v;
    if (!capturing) armed = v;
  endtask

  initial begin
    logic [7:0] q[$];
    rst_n      = 1'b0;
    capture_en = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b1;
    cam_din    = 8'($urandom);

    // Reset held for three cycles while HREF is active.
    repeat (3) begin
      @(negedge pclk);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      cam_din = 8'($urandom);
    end
    @(negedge pclk);
    rst_n    = 1'b1;
    cam_href = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("idle_busy", 32'(busy), 32'd0);

    // Frame 1: known pixel values, random lines, odd byte, row clipping.
    set_en(1'b1);
    vsync_frame();
    check("busy_f1", 32'(busy), 32'(capturing));
    q = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hF8, 8'h00};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    send_line(q);
    rand_line(10);
    rand_line(5);
    rand_line(8);
    rand_line(6);

    // Frame 2: 642-pixel line clipped to 640, then a 2-pixel line; disable mid-frame.
    vsync_frame();
    check("busy_f2", 32'(busy), 32'(capturing));
    rand_line(2 * 642);
    rand_line(4);
    set_en(1'b0);
    rand_line(6);

    // Frame 3: not captured; arming mid-frame waits for the next VSYNC fall.
    vsync_frame();
    check("busy_f3", 32'(busy), 32'(capturing));
    rand_line(8);
    set_en(1'b1);
    rand_line(8);

    // Frame 4: captured from addr 0, then reset mid-frame drops the rest.
    vsync_frame();
    check("busy_f4", 32'(busy), 32'(capturing));
    rand_line(6);
    rand_line(4);
    @(negedge pclk);
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    capturing = 1'b0;
    armed     = capture_en;
    check("rst_mid_busy", 32'(busy), 32'd0);
    rand_line(6);

    // Frame 5: re-armed after reset, captured normally.
    vsync_frame();
    check("busy_f5", 32'(busy), 32'(capturing));
    rand_line(8);
    vsync_frame();
    repeat (10) step(1'b0, 1'b0, 8'h00);

    check("writes_left", exp_wr.size(), 32'd0);
    check("frame_done_left", exp_fd.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage feeding the frame buffer that the VGA scan-out block reads. Receives the OV7670 RGB565 byte stream (PCLK/HREF/VSYNC/D[7:0]), pairs bytes into pixels, and converts each pixel to 4-bit gray. Writes pixels in raster order into the 19-bit-addressed frame buffer, at the address and value the VGA reader later fetches as `frame_pixel`. Captures only whole frames, aligned to VSYNC.

## Interface
Parameters:
- `hRez`, 640, pixels written per line; pixels beyond this are dropped.
- `vRez`, 480, lines written per frame; lines beyond this are dropped.

Ports:
- `pclk`  input  1  camera pixel clock; the only clock.
- `rst_n`  input  1  reset, synchronous, active-low.
- `capture_en`  input  1  level; enables arming for the next frame.
- `cam_vsync`  input  1  camera VSYNC, high = vertical blanking.
- `cam_href`  input  1  camera HREF, high = valid bytes on `cam_din`.
- `cam_din`  input  8  camera data byte.
- `wr_en`  output  1  frame buffer write strobe, one cycle per pixel.
- `wr_addr`  output  19  frame buffer address, row*hRez+col.
- `wr_data`  output  4  gray pixel value.
- `frame_done`  output  1  one-cycle pulse at the end of each captured frame.
- `busy`  output  1  high while in state CAPTURE.

## Operation
- Input stage:
  - `cam_vsync`, `cam_href` and `cam_din` are registered once into `vs_q`, `hr_q` and `d_q`.
  - All logic below uses only the registered copies.
  - `vs_rise` = `vs_q` & ~previous `vs_q`. `vs_fall` is defined likewise.
- States are IDLE, ARM and CAPTURE; reset enters IDLE.
  - IDLE → ARM when `capture_en`=1.
  - ARM → CAPTURE on `vs_fall`. On entry, clear `col`, `row` and the address counter.
  - ARM → IDLE when `capture_en`=0 and there is no `vs_fall` in that cycle.
  - CAPTURE → ARM on `vs_rise` when `capture_en`=1; otherwise CAPTURE → IDLE. Both transitions pulse `frame_done`.
  - Deasserting `capture_en` mid-frame does not abort; the frame completes.
- Byte pairing:
  - A `phase` bit toggles on each cycle in CAPTURE with `hr_q`=1, and is forced to 0 when `hr_q`=0.
  - phase 0 latches byte0 = {R[4:0],G[5:3]}.
  - phase 1 completes the pixel: byte1 = {G[2:0],B[4:0]}.
  - An odd trailing byte at the HREF falling edge is discarded.
- Gray conversion: sum[6:0] = R5 + G6 + B5 (range 0..125); `wr_data` = sum[6:3] (range 0..15). No saturation is needed.
- Counters:
  - `col` increments per completed pixel.
  - On the `hr_q` falling edge with `col`>0, `row` increments and `col` clears.
  - A pixel is written only if `col`<hRez and `row`<vRez.
  - The address counter increments only on performed writes; `wr_addr` is always equal to row*hRez+col of the written pixel.
- `busy`=1 exactly in CAPTURE.

## Timing
- Reset values, applied on a `pclk` edge with `rst_n`=0:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `busy`=0.
  - State=IDLE; `phase`, `col`, `row` and the input registers cleared.
- Reset during CAPTURE drops the partial frame: no further writes and no `frame_done`.
- Write latency:
  - Second byte on `cam_din` at edge E → `d_q` at E.
  - `wr_en`, `wr_addr` and `wr_data` are registered at E+1 and valid for exactly one cycle (E+1 to E+2).
- Maximum write rate is one write every 2 cycles; `wr_en` is never high on consecutive cycles.
- `frame_done` rises at the edge after `vs_q` rises, i.e. 2 edges after `cam_vsync` rises. A write completing in the same cycle is still issued.
- `vs_fall` and `hr_q`=1 in the same cycle: that byte is ignored, because capture starts on the next cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles during active HREF → all outputs 0, no `wr_en`.
- Pixel values: arm, first line bytes 0xFF,0xFF then 0x00,0x00 → write (addr 0, data 15) then (addr 1, data 0); `wr_en` 2 cycles after each second byte.
- Mixed colour: bytes 0xF8,0x00 (pure red, R5=31) → `wr_data`=3.
- Line clipping: line 0 of 642 pixels, line 1 of 2 pixels → 640 writes (addr 0..639), then addr 640 and 641; no write for pixels 640 and 641 of line 0.
- Odd byte and frame end: a line of 5 bytes → 2 writes only. `cam_vsync` rise → `frame_done` pulse; with `capture_en`=0 → IDLE, `busy`=0, and no writes in the following frame.
- Arming alignment: `capture_en` raised mid-frame → no writes until after the next VSYNC falling edge; the first write is at addr 0.
